// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin two-port arbiter in front of a single unified RAM.
// Port 0 is the CPU, port 1 the loader/debug DMA. One beat is granted per cycle;
// a locking owner may keep the RAM for up to MAX_BURST beats while the other port waits.
module mem_arbiter #(
    parameter int unsigned MAX_BURST = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0,
    input  logic        req1,
    input  logic        lock0,
    input  logic        lock1,
    input  logic        we0,
    input  logic        we1,
    input  logic [31:0] addr0,
    input  logic [31:0] addr1,
    input  logic [31:0] wdata0,
    input  logic [31:0] wdata1,
    output logic        gnt0,
    output logic        gnt1,
    output logic        rvalid0,
    output logic        rvalid1,
    output logic [31:0] rdata0,
    output logic [31:0] rdata1,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_wdata,
    output logic        ram_we,
    input  logic [31:0] ram_rdata,
    output logic [1:0]  owner_debug
);

    localparam int unsigned CntW = $clog2(MAX_BURST + 1);
    localparam logic [CntW:0] MaxWide = (CntW + 1)'(MAX_BURST);
    localparam logic [CntW-1:0] MaxCnt = CntW'(MAX_BURST);

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StOwn0 = 2'b01,
        StOwn1 = 2'b10
    } state_e;

    state_e          state_q, state_d;
    logic            last_q, last_d;   // port that owned the RAM most recently
    logic [CntW-1:0] cnt_q, cnt_d;     // beats already taken in the current tenure
    logic [CntW:0]   cnt_inc;          // one bit wider so cnt+1 never wraps
    logic [CntW-1:0] cnt_sat;

    assign cnt_inc = {1'b0, cnt_q} + {{CntW{1'b0}}, 1'b1};
    assign cnt_sat = (cnt_inc > MaxWide) ? MaxCnt : cnt_inc[CntW-1:0];

    // State register with synchronous active-low reset; port 0 wins the first tie.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= StIdle;
            last_q  <= 1'b1;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state: round-robin entry from idle, bounded locked bursts under contention.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (req0 && req1) begin
                    state_d = last_q ? StOwn0 : StOwn1;
                end else if (req0) begin
                    state_d = StOwn0;
                end else if (req1) begin
                    state_d = StOwn1;
                end
            end
            StOwn0: begin
                if (!req1) begin
                    if (req0) begin
                        cnt_d = cnt_sat;
                    end else begin
                        state_d = StIdle;
                        last_d  = 1'b0;
                        cnt_d   = '0;
                    end
                end else if (req0 && lock0 && (cnt_inc < MaxWide)) begin
                    cnt_d = cnt_inc[CntW-1:0];
                end else begin
                    // Hand over with no bubble: port 1 gets its first beat next cycle.
                    state_d = StOwn1;
                    last_d  = 1'b0;
                    cnt_d   = '0;
                end
            end
            StOwn1: begin
                if (!req0) begin
                    if (req1) begin
                        cnt_d = cnt_sat;
                    end else begin
                        state_d = StIdle;
                        last_d  = 1'b1;
                        cnt_d   = '0;
                    end
                end else if (req1 && lock1 && (cnt_inc < MaxWide)) begin
                    cnt_d = cnt_inc[CntW-1:0];
                end else begin
                    state_d = StOwn0;
                    last_d  = 1'b1;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    // Grants are combinational so a dropped req or an asserted reset kills the beat at once.
    always_comb begin
        gnt0    = (state_q == StOwn0) && req0 && reset;
        gnt1    = (state_q == StOwn1) && req1 && reset;
        ram_we  = (gnt0 && we0) || (gnt1 && we1);
        rvalid0 = gnt0 && !we0;
        rvalid1 = gnt1 && !we1;
    end

    // RAM address/data follow the current owner; both read ports share the RAM read path.
    always_comb begin
        ram_addr  = '0;
        ram_wdata = '0;
        case (state_q)
            StOwn0: begin
                ram_addr  = addr0;
                ram_wdata = wdata0;
            end
            StOwn1: begin
                ram_addr  = addr1;
                ram_wdata = wdata1;
            end
            default: begin
                ram_addr  = '0;
                ram_wdata = '0;
            end
        endcase
    end

    assign rdata0      = ram_rdata;
    assign rdata1      = ram_rdata;
    assign owner_debug = state_q;

endmodule
